ntt_btf_sched: RTL
==================

# ntt_btf_sched

Butterfly scheduler for an in-place radix-2 N-point NTT held in a dual-port coefficient RAM. It walks every stage, group and butterfly and issues paired read addresses plus a twiddle-ROM address each cycle. The read data feeds the twiddle multiplier and then `btf_addsub`. Write-back addresses are delayed by the fixed datapath latency, and a drain gap between stages prevents read-after-write hazards.

## Interface
Parameters:
- `LOGN`, default 8: log2 of transform size; N = 2^LOGN, LOGN ≥ 2.
- `PIPE_LAT`, default 4: cycles from RAM read address to matching `btf_addsub` output (RAM read + multiplier + add/sub), ≥ 1.
- `STG_W`, default $clog2(LOGN): stage index width (derived; do not override).

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: one-cycle request to begin a transform; ignored while `busy`.
- `busy` output 1: high from the cycle after accepted `start` through the cycle `done` pulses.
- `done` output 1: one-cycle pulse after the final write-back.
- `stage` output STG_W: current stage index s.
- `rd_en` output 1: read strobe for both RAM ports.
- `rd_addr_a` output LOGN: top butterfly operand address, to `in_a`.
- `rd_addr_b` output LOGN: bottom operand address, to the multiplier.
- `tw_addr` output LOGN: twiddle ROM address.
- `wr_en` output 1: write strobe for `out_sum`/`out_diff`.
- `wr_addr_a` output LOGN: destination of `out_sum`.
- `wr_addr_b` output LOGN: destination of `out_diff`.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, FIN.
  - IDLE: `start` → ISSUE with s = 0 and k = 0.
  - ISSUE: one butterfly per cycle, k = 0 … N/2−1. At k = N/2−1 → DRAIN.
  - DRAIN: counts PIPE_LAT cycles with `rd_en` low. At the end, if s is the last stage → FIN; otherwise increment s, clear k → ISSUE.
  - FIN: `done` = 1 for one cycle → IDLE.
- Address arithmetic, forward Cooley-Tukey, per stage s:
  - h = N >> (s+1), g = k >> (LOGN−1−s), j = k & (h−1).
  - `rd_addr_a` = (g << (LOGN−s)) | j.
  - `rd_addr_b` = `rd_addr_a` + h.
  - `tw_addr` = (1 << s) + g.
  - All values are unsigned and LOGN bits wide. Use shifts and masks only; no multipliers.
- Write-back path:
  - `wr_en`, `wr_addr_a` and `wr_addr_b` are `rd_en`, `rd_addr_a` and `rd_addr_b` delayed by exactly PIPE_LAT cycles.
  - The delay line is not frozen by FSM state.
- `start` arriving while `busy` is dropped: no queueing, no restart.
- `start` in the same cycle as the FIN→IDLE transition is ignored. A new `start` is accepted in IDLE only.

## Timing
- Reset values: all outputs 0, FSM in IDLE, delay line cleared.
- Reset asserted mid-transform:
  - Everything clears immediately.
  - No further `wr_en` pulses occur, including in-flight ones.
  - `done` is not pulsed.
- Sequence from an accepted `start`:
  - `start` is sampled high in cycle 0.
  - `busy` and the first `rd_en` are high in cycle 1.
  - Each stage occupies N/2 + PIPE_LAT cycles.
  - The last write of a stage occurs one cycle before the first read of the next stage.
- Total: `rd_en` first high in cycle 1; the final `wr_en` is in cycle LOGN·(N/2+PIPE_LAT). `done` is high in the cycle after that, and `busy` deasserts with it.
- `stage` updates on the DRAIN→ISSUE edge. `stage` refers to the issue side, not the write side.

## Configuration
- Macro: `NTT_SCHED_INTT_EN`.
- Defined:
  - Adds input `inverse` (1), sampled at accepted `start`, and output `tw_inv` (1), equal to the latched `inverse`.
  - With `inverse` = 1, stages run in the order s = LOGN−1 down to 0 (Gentleman-Sande ordering). `stage` counts down.
  - The same address formulas apply for the current s.
- Undefined: forward only. Neither port exists.

## Structure
- Package `ntt_pkg`:
  - FSM state enum.
  - `btf_addr` function computing (`rd_addr_a`, `rd_addr_b`, `tw_addr`) from (s, k, LOGN).
- Sub-module `ntt_delay_line`: a PIPE_LAT-deep shift register of {valid, addr_a, addr_b} with asynchronous active-low clear. It must be reusable for twiddle-path alignment.

## Test plan
Unless noted, LOGN = 3 (N = 8) and PIPE_LAT = 2.
- Stage 0 read sequence: `start` → cycles 1–4 give a = 0,1,2,3; b = 4,5,6,7; tw = 1,1,1,1. Cycles 5–6 have `rd_en` = 0.
- Stage 1 and 2 read sequences:
  - Stage 1: a = 0,1,4,5; b = 2,3,6,7; tw = 2,2,3,3.
  - Stage 2: a = 0,2,4,6; b = 1,3,5,7; tw = 4,5,6,7.
- Write-back timing:
  - Every `wr_en`/`wr_addr` pair equals the corresponding read pair 2 cycles earlier.
  - The last `wr_en` is in cycle 18, `done` pulses in cycle 19 and `busy` falls with it.
- Dropped start: `start` pulsed in cycles 3 and 10 → ignored. The sequence is identical to the single-start run.
- Mid-run reset: `rst_n` low in cycle 7 → all outputs 0 immediately. No `wr_en` appears afterwards, and a fresh `start` restarts from stage 0.
- Inverse mode: with `NTT_SCHED_INTT_EN` defined and `inverse` = 1, the run issues stage 2's sequence first, then stage 1, then stage 0, with `tw_inv` = 1.

Source files
------------

// File: rtl/ntt_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : ntt_pkg
// Brief    : Shared FSM state type and butterfly address helper for ntt_btf_sched.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
package ntt_pkg;

    localparam int unsigned c_MAX_LOGN = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    typedef struct packed {
        logic [c_MAX_LOGN-1:0] a;
        logic [c_MAX_LOGN-1:0] b;
        logic [c_MAX_LOGN-1:0] tw;
    } btf_addr_t;

    // Forward Cooley-Tukey addressing for butterfly k of stage s; shifts and masks only.
    function automatic btf_addr_t btf_addr(input logic [31:0] s,
                                           input logic [31:0] k,
                                           input logic [31:0] logn);
        logic [31:0] w_h;
        logic [31:0] w_g;
        logic [31:0] w_j;
        logic [31:0] w_a;
        logic [31:0] w_b;
        logic [31:0] w_t;
        btf_addr_t   w_res;
        w_h = (32'd1 << logn) >> (s + 32'd1);
        w_g = k >> (logn - 32'd1 - s);
        w_j = k & (w_h - 32'd1);
        w_a = (w_g << (logn - s)) | w_j;
        w_b = w_a + w_h;
        w_t = (32'd1 << s) + w_g;
        w_res.a  = w_a[c_MAX_LOGN-1:0];
        w_res.b  = w_b[c_MAX_LOGN-1:0];
        w_res.tw = w_t[c_MAX_LOGN-1:0];
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ntt_btf_sched_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : ntt_btf_sched_if
// Brief    : Control/address bundle of the NTT butterfly scheduler.
//            NTT_SCHED_INTT_EN adds inverse / tw_inv.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
interface ntt_btf_sched_if #(
    parameter int LOGN  = 8,
    parameter int STG_W = $clog2(LOGN)
);
    logic             start;
    logic             busy;
    logic             done;
    logic [STG_W-1:0] stage;
    logic             rd_en;
    logic [LOGN-1:0]  rd_addr_a;
    logic [LOGN-1:0]  rd_addr_b;
    logic [LOGN-1:0]  tw_addr;
    logic             wr_en;
    logic [LOGN-1:0]  wr_addr_a;
    logic [LOGN-1:0]  wr_addr_b;
`ifdef NTT_SCHED_INTT_EN
    logic             inverse;
    logic             tw_inv;
`endif

    modport master (
`ifdef NTT_SCHED_INTT_EN
        output inverse,
        input  tw_inv,
`endif
        output start,
        input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
        input  wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
`ifdef NTT_SCHED_INTT_EN
        input  inverse,
        output tw_inv,
`endif
        input  start,
        output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
        output wr_en, wr_addr_a, wr_addr_b
    );
endinterface
`default_nettype wire

// File: rtl/ntt_delay_line.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : ntt_delay_line
// Brief    : DEPTH-stage shift register of {valid, addr_a, addr_b}, async clear.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module ntt_delay_line #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         valid_i,
    input  wire logic [W-1:0] a_i,
    input  wire logic [W-1:0] b_i,
    output logic              valid_o,
    output logic [W-1:0]      a_o,
    output logic [W-1:0]      b_o
);
    localparam int c_EW = 2 * W + 1;

    logic [c_EW-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= {valid_i, a_i, b_i};
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign {valid_o, a_o, b_o} = pipe_q[DEPTH-1];
endmodule
`default_nettype wire

// File: rtl/ntt_btf_sched.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : ntt_btf_sched
// Brief    : In-place radix-2 NTT butterfly scheduler with write-back delay line.
//            NTT_SCHED_INTT_EN enables reversed (Gentleman-Sande) stage order.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module ntt_btf_sched
    import ntt_pkg::*;
#(
    parameter int LOGN     = 8,
    parameter int PIPE_LAT = 4,
    parameter int STG_W    = $clog2(LOGN)
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    ntt_btf_sched_if.slave    bus
);
    localparam int               c_CNT_W  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [LOGN-2:0]  c_K_LAST = '1;
    localparam logic [STG_W-1:0] c_S_LAST = STG_W'(LOGN - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(PIPE_LAT - 1);

    state_e             state_q, state_d;
    logic [STG_W-1:0]   stage_q, stage_d;
    logic [LOGN-2:0]    k_q, k_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               inv_q, inv_d;
    logic               w_inv_start;
    logic               w_last_stage;
    logic               w_rd_en;
    btf_addr_t          w_addr;

`ifdef NTT_SCHED_INTT_EN
    assign w_inv_start = bus.inverse;
    assign bus.tw_inv  = inv_q;
`else
    assign w_inv_start = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
        end
    end

    assign w_last_stage = inv_q ? (stage_q == '0) : (stage_q == c_S_LAST);

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_ISSUE;
                    k_d     = '0;
                    cnt_d   = '0;
                    inv_d   = w_inv_start;
                    stage_d = w_inv_start ? c_S_LAST : '0;
                end
            end
            ST_ISSUE: begin
                k_d = k_q + (LOGN-1)'(1);
                if (k_q == c_K_LAST) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            // Reads stay idle until the stage's last write has left the datapath.
            ST_DRAIN: begin
                cnt_d = cnt_q + c_CNT_W'(1);
                if (cnt_q == c_CNT_LAST) begin
                    if (w_last_stage) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_ISSUE;
                        k_d     = '0;
                        stage_d = inv_q ? (stage_q - STG_W'(1)) : (stage_q + STG_W'(1));
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign w_rd_en = (state_q == ST_ISSUE);
    assign w_addr  = btf_addr(32'(stage_q), 32'(k_q), 32'(LOGN));

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_FIN);
    assign bus.stage     = stage_q;
    assign bus.rd_en     = w_rd_en;
    assign bus.rd_addr_a = w_rd_en ? w_addr.a[LOGN-1:0]  : '0;
    assign bus.rd_addr_b = w_rd_en ? w_addr.b[LOGN-1:0]  : '0;
    assign bus.tw_addr   = w_rd_en ? w_addr.tw[LOGN-1:0] : '0;

    ntt_delay_line #(
        .DEPTH (PIPE_LAT),
        .W     (LOGN)
    ) u_wb_dly (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (bus.rd_en),
        .a_i     (bus.rd_addr_a),
        .b_i     (bus.rd_addr_b),
        .valid_o (bus.wr_en),
        .a_o     (bus.wr_addr_a),
        .b_o     (bus.wr_addr_b)
    );
endmodule
`default_nettype wire
